// File: rtl/shared_reg_arbiter.sv
// Shared register with 4-way round-robin write arbitration.
// Define SHARED_REG_ARBITER_LOCK_EN to add LOCK and locked bursts.
module shared_reg_arbiter #(
  parameter int WIDTH    = 8,
  parameter int LOCK_MAX = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [3:0]         REQ,
  input  logic [4*WIDTH-1:0] DIN,
`ifdef SHARED_REG_ARBITER_LOCK_EN
  input  logic [3:0]         LOCK,
`endif
  output logic [3:0]         GNT,
  output logic [1:0]         OWNER,
  output logic               ACK,
  output logic [WIDTH-1:0]   Q,
  output logic               BUSY
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  if (LOCK_MAX < 1) begin : g_bad_lock_max
    $error("LOCK_MAX must be at least 1");
  end

  logic [0:0]       state_q, state_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       owner_q, owner_d;
  logic             ack_q, ack_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [1:0]       last_q, last_d;

  logic [WIDTH-1:0] din_a [4];
  logic [1:0]       rr_win;
  logic [1:0]       rr_idx;
  logic             rr_hit;
  logic             lock_go;

  for (genvar i = 0; i < 4; i++) begin : g_din
    assign din_a[i] = DIN[i*WIDTH +: WIDTH];
  end

`ifdef SHARED_REG_ARBITER_LOCK_EN
  localparam int CW = $clog2(LOCK_MAX + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  // Continue the burst while the owner locks and budget remains
  always_comb begin
    lock_go = LOCK[owner_q] && (cnt_q < CW'(LOCK_MAX - 1));
  end
`else
  // No lock support: every grant ends after one write
  always_comb begin
    lock_go = 1'b0;
  end
`endif

  // Round-robin search starting just after the last writer
  always_comb begin
    rr_win = last_q + 2'd1;
    rr_idx = 2'd0;
    rr_hit = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      rr_idx = last_q + k[1:0];
      if (!rr_hit && REQ[rr_idx]) begin
        rr_win = rr_idx;
        rr_hit = 1'b1;
      end
    end
  end

  // Next-state and datapath decisions
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ack_d   = 1'b0;
    q_d     = q_q;
    last_d  = last_q;
`ifdef SHARED_REG_ARBITER_LOCK_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (rr_hit) begin
          state_d = S_GRANT;
          gnt_d   = 4'b0001 << rr_win;
          owner_d = rr_win;
        end else begin
          gnt_d = 4'b0000;
        end
      end
      S_GRANT: begin
        if (REQ[owner_q]) begin
          q_d    = din_a[owner_q];
          ack_d  = 1'b1;
          last_d = owner_q;
          if (lock_go) begin
`ifdef SHARED_REG_ARBITER_LOCK_EN
            cnt_d = cnt_q + CW'(1);
`endif
          end else begin
            state_d = S_IDLE;
            gnt_d   = 4'b0000;
`ifdef SHARED_REG_ARBITER_LOCK_EN
            cnt_d   = '0;
`endif
          end
        end else begin
          state_d = S_IDLE;
          gnt_d   = 4'b0000;
`ifdef SHARED_REG_ARBITER_LOCK_EN
          cnt_d   = '0;
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      gnt_q   <= 4'b0000;
      owner_q <= 2'd0;
      ack_q   <= 1'b0;
      q_q     <= '0;
      last_q  <= 2'd3;
`ifdef SHARED_REG_ARBITER_LOCK_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ack_q   <= ack_d;
      q_q     <= q_d;
      last_q  <= last_d;
`ifdef SHARED_REG_ARBITER_LOCK_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign GNT   = gnt_q;
  assign OWNER = owner_q;
  assign ACK   = ack_q;
  assign Q     = q_q;
  assign BUSY  = (state_q == S_GRANT);

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Randomized + directed bench for shared_reg_arbiter.
// Checks every cycle against a transaction-level model.
module tb_shared_reg_arbiter;

  localparam int W  = 8;
  localparam int LM = 4;

  logic         CLK = 1'b0;
  logic         RST;
  logic [3:0]   REQ;
  logic [4*W-1:0] DIN;
  logic [3:0]   LOCK;
  logic [3:0]   GNT;
  logic [1:0]   OWNER;
  logic         ACK;
  logic [W-1:0] Q;
  logic         BUSY;

  int n_pass = 0;
  int n_total = 0;

  // reference model state
  bit       m_busy;
  int       m_owner;
  int       m_last;
  int       m_cnt;
  bit       m_ack;
  logic [W-1:0] m_q;

  shared_reg_arbiter #(.WIDTH(W), .LOCK_MAX(LM)) dut (
    .CLK(CLK),
    .RST(RST),
    .REQ(REQ),
    .DIN(DIN),
`ifdef SHARED_REG_ARBITER_LOCK_EN
    .LOCK(LOCK),
`endif
    .GNT(GNT),
    .OWNER(OWNER),
    .ACK(ACK),
    .Q(Q),
    .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic logic [W-1:0] din_of(input logic [4*W-1:0] d,
                                          input int c);
    return d[c*W +: W];
  endfunction

  // one clock of the model, from the spec's transaction rules
  task automatic model_step;
    bit lock_en;
`ifdef SHARED_REG_ARBITER_LOCK_EN
    lock_en = 1'b1;
`else
    lock_en = 1'b0;
`endif
    m_ack = 1'b0;
    if (RST) begin
      m_busy = 0; m_owner = 0; m_last = 3;
      m_cnt = 0;  m_q = '0;
    end else if (!m_busy) begin
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (m_last + k) % 4;
        if (!m_busy && REQ[c]) begin
          m_busy = 1; m_owner = c;
        end
      end
    end else if (REQ[m_owner]) begin
      m_q = din_of(DIN, m_owner);
      m_ack = 1'b1;
      m_last = m_owner;
      if (lock_en && LOCK[m_owner] && m_cnt < LM - 1) begin
        m_cnt++;
      end else begin
        m_busy = 0; m_cnt = 0;
      end
    end else begin
      m_busy = 0; m_cnt = 0;
    end
  endtask

  task automatic tick(input logic rst, input logic [3:0] req,
                      input logic [4*W-1:0] din,
                      input logic [3:0] lock);
    logic [3:0] exp_gnt;
    @(negedge CLK);
    RST = rst; REQ = req; DIN = din; LOCK = lock;
    @(posedge CLK);
    model_step();
    #1;
    exp_gnt = m_busy ? (4'b0001 << m_owner) : 4'b0000;
    chk("gnt",   GNT,   exp_gnt);
    chk("owner", OWNER, m_owner);
    chk("ack",   ACK,   m_ack);
    chk("q",     Q,     m_q);
    chk("busy",  BUSY,  m_busy);
  endtask

  logic [4*W-1:0] dset;
  int exp_ord [5] = '{0, 1, 2, 3, 0};
  int n_ack;
  int prev_ack;

  initial begin
    RST = 1'b1; REQ = '0; DIN = '0; LOCK = '0;
    m_busy = 0; m_owner = 0; m_last = 3;
    m_cnt = 0; m_ack = 0; m_q = '0;
    dset = {8'h44, 8'h33, 8'h22, 8'h11};

    tick(1, 4'b0000, '0, '0);
    tick(1, 4'b1111, dset, '0);
    chk("rst_gnt", GNT, 4'b0000);
    chk("rst_q", Q, 8'h00);

    // single write from requester 0
    tick(0, 4'b0001, {24'h0, 8'hA5}, '0);
    chk("w0_gnt", GNT, 4'b0001);
    tick(0, 4'b0001, {24'h0, 8'hA5}, '0);
    chk("w0_q", Q, 8'hA5);
    chk("w0_ack", ACK, 1'b1);
    chk("w0_busy", BUSY, 1'b0);
    tick(0, 4'b0000, '0, '0);
    chk("w0_ack_lo", ACK, 1'b0);

    // full contention: rotation 0,1,2,3,0
    tick(1, 4'b0000, '0, '0);
    n_ack = 0;
    for (int i = 0; i < 10; i++) begin
      tick(0, 4'b1111, dset, '0);
      if (ACK) begin
        if (n_ack < 5) chk("rr_order", OWNER, exp_ord[n_ack]);
        n_ack++;
      end
    end
    chk("rr_acks", n_ack, 5);

    // abort: owner drops request while granted
    tick(0, 4'b0100, dset, '0);
    chk("ab_gnt", GNT, 4'b0100);
    tick(0, 4'b0000, dset, '0);
    chk("ab_ack", ACK, 1'b0);
    chk("ab_q", Q, 8'h11);
    chk("ab_busy", BUSY, 1'b0);

    // reset in grant, then priority restarts at 0
    tick(0, 4'b0100, dset, '0);
    chk("rg_gnt", GNT, 4'b0100);
    tick(1, 4'b0100, dset, '0);
    chk("rg_ack", ACK, 1'b0);
    chk("rg_q", Q, 8'h00);
    chk("rg_gnt0", GNT, 4'b0000);
    tick(0, 4'b0110, dset, '0);
    chk("rg_own", OWNER, 2'd1);

`ifdef SHARED_REG_ARBITER_LOCK_EN
    // locked burst from requester 3, then forced release
    tick(1, 4'b0000, '0, '0);
    tick(0, 4'b1000, dset, 4'b1000);
    chk("lk_gnt", GNT, 4'b1000);
    n_ack = 0;
    for (int i = 0; i < 4; i++) begin
      tick(0, 4'b1001, dset, 4'b1000);
      if (ACK && OWNER == 2'd3) n_ack++;
    end
    chk("lk_acks", n_ack, 4);
    chk("lk_rel", BUSY, 1'b0);
    tick(0, 4'b1001, dset, 4'b1000);
    chk("lk_next", OWNER, 2'd0);
`endif

    // random traffic, model-checked every cycle
    prev_ack = 0;
    for (int i = 0; i < 400; i++) begin
      logic [4*W-1:0] d;
      logic r;
      d = {$urandom, $urandom};
      r = ($urandom_range(0, 39) == 0);
      tick(r, 4'($urandom), d, 4'($urandom));
`ifndef SHARED_REG_ARBITER_LOCK_EN
      if (prev_ack == 1 && ACK) chk("ack_b2b", ACK, 1'b0);
`endif
      prev_ack = int'(ACK);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/shared_reg_arbiter.md
SHARED_REG_ARBITER -- requirements
Module: shared_reg_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, data width of the shared register and of each requester data port.
REQ-002 Parameter LOCK_MAX, default 4, maximum consecutive locked writes per grant (used only with LOCK_EN).
REQ-003 CLK  input  1  clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, synchronous and active-high.
REQ-005 REQ  input  4  per-requester write request, bit i = requester i.
REQ-006 DIN  input  4*WIDTH  packed write data, requester i at bits [i*WIDTH +: WIDTH].
REQ-007 LOCK  input  4  per-requester lock request (present only with LOCK_EN).
REQ-008 GNT  output  4  registered one-hot grant, all-zero when idle.
REQ-009 OWNER  output  2  registered index of current/last granted requester.
REQ-010 ACK  output  1  registered one-cycle pulse per completed write.
REQ-011 Q  output  WIDTH  shared register contents.
REQ-012 BUSY  output  1  high while the FSM is not IDLE.

Function
REQ-013 FSM SHALL have exactly two states, IDLE and GRANT; BUSY = (state == GRANT).
REQ-014 In IDLE, at an edge with REQ != 0, the block SHALL pick the winner round-robin, searching from (LAST+1) mod 4 upward with wrap, and enter GRANT with GNT = one-hot(winner), OWNER = winner.
REQ-015 In IDLE with REQ == 0, the block SHALL remain in IDLE with GNT = 0 and Q unchanged.
REQ-016 In GRANT, at an edge where REQ[OWNER] = 1, Q SHALL load DIN[OWNER], ACK SHALL be 1 for the following cycle, and LAST SHALL become OWNER.
REQ-017 In GRANT, at an edge where REQ[OWNER] = 0, the grant SHALL abort: no write, ACK = 0, GNT = 0, next state IDLE, LAST unchanged.
REQ-018 Without a lock continuation, GRANT SHALL return to IDLE after one write, so an unlocked transaction is: REQ sampled at edge E0, write and ACK at edge E1, next arbitration at E2 earliest.
REQ-019 ACK SHALL never be high for two consecutive cycles except during locked back-to-back writes.
REQ-020 REQ changes of non-owners during GRANT SHALL be ignored until the FSM is back in IDLE.
REQ-021 GNT SHALL be one-hot or zero in every cycle; OWNER SHALL hold its value in IDLE.

Reset
REQ-022 With RST high at an edge, the block SHALL set state = IDLE, GNT = 0, OWNER = 0, ACK = 0, Q = 0, LAST = 3 and lock count = 0, overriding all other inputs.
REQ-023 A reset asserted in GRANT SHALL abort the transaction with no write and no ACK.
REQ-024 After reset release, requester 0 SHALL have the highest priority for the first arbitration.

Configuration
REQ-025 Macro SHARED_REG_ARBITER_LOCK_EN SHALL compile in the LOCK port and the lock counter.
REQ-026 With the macro defined: on a write edge in GRANT with LOCK[OWNER] = 1 and lock count < LOCK_MAX-1, the block SHALL stay in GRANT, keep GNT, and increment the count; otherwise it SHALL return to IDLE and clear the count.
REQ-027 With the macro defined, a locked owner SHALL therefore complete at most LOCK_MAX consecutive writes (one per cycle) before forced release.
REQ-028 Without the macro, the LOCK port and the counter SHALL be absent, and behaviour SHALL be exactly REQ-018.

Verification
REQ-029 Reset then REQ=4'b0001, DIN0=8'hA5 for 1 cycle: GNT=0001 next cycle, then Q=8'hA5 and ACK=1 for 1 cycle, BUSY back to 0.
REQ-030 REQ=4'b1111 held with distinct DIN values: grant order 0,1,2,3,0, with a new ACK every 2 cycles.
REQ-031 REQ=4'b0100 dropped to 0 in the GRANT cycle: no ACK, Q unchanged, FSM in IDLE one cycle later.
REQ-032 RST pulsed during GRANT of requester 2: ACK=0, Q=0, GNT=0; the next REQ=4'b0110 is granted to requester 1.
REQ-033 LOCK_EN, LOCK_MAX=4, REQ[3] and LOCK[3] held high with REQ[0] also high: four consecutive ACKs from requester 3, forced release, then requester 0 granted.
